// File: rtl/chip_frame_deserializer.sv
// Purpose: oversampled chip-line receiver; recovers chip timing from the frame's leading edge and majority-votes each chip into a CHIP_LEN-bit frame.
// Latency: start/reject OVERSAMPLE*CHIP_LEN cycles after the leading edge is seen (30 cycles after rx_in rises, defaults).
// Backpressure: none; an accepted frame is frozen HOLDOFF cycles, rx edges meanwhile only raise overrun.
// Ports: clk, nRst (sync, active-low); enable, rx_in in; m_sequence, start, reject, frame_count, overrun out (all registered).
module chip_frame_deserializer #(
    parameter int OVERSAMPLE = 4,
    parameter int CHIP_LEN   = 7,
    parameter int HOLDOFF    = 15
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                enable,
    input  logic                rx_in,
    output logic [CHIP_LEN-1:0] m_sequence,
    output logic                start,
    output logic                reject,
    output logic [7:0]          frame_count,
    output logic                overrun
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam int CH_W = $clog2(CHIP_LEN + 1);
    localparam int HD_W = $clog2(HOLDOFF + 1);

    localparam logic [PH_W-1:0] PH_1    = PH_W'(1);
    localparam logic [PH_W-1:0] PH_2    = PH_W'(2);
    localparam logic [PH_W-1:0] PH_3    = PH_W'(3);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHIP_LEN - 1);
    localparam logic [HD_W-1:0] HD_LAST = HD_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_COLLECT = 3'd2,
        ST_EMIT    = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_meta_d;
    logic                rx_s_q, rx_s_d;
    logic                rx_d_q, rx_d_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CH_W-1:0]     chip_q, chip_d;
    logic [1:0]          votes_q, votes_d;
    logic [CHIP_LEN-1:0] shift_q, shift_d;
    logic [HD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [CHIP_LEN-1:0] m_seq_q, m_seq_d;
    logic                start_q, start_d;
    logic                reject_q, reject_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic                overrun_q, overrun_d;

    logic       rx_edge;
    logic       phase_last;
    logic       vote_inc;
    logic [1:0] vote_sum;
    logic       chip_bit;
    logic       word_ok;

    assign rx_edge    = rx_s_q ^ rx_d_q;
    assign phase_last = (phase_q == PH_LAST);
    // Only phases 1..3 vote; phase 0 sits on the chip boundary.
    assign vote_inc   = rx_s_q & ((phase_q == PH_1) | (phase_q == PH_2) | (phase_q == PH_3));
    // The phase-3 sample counts toward the chip committed in that same cycle.
    assign vote_sum   = votes_q + {1'b0, vote_inc};
    assign chip_bit   = (vote_sum >= 2'd2);
    assign word_ok    = (|shift_q) & ~(&shift_q);

    // State register
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (!enable)     state_d = ST_IDLE;
                else if (rx_edge) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (!enable)                             state_d = ST_IDLE;
                else if (phase_last && chip_q == CH_LAST) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                // The pulse is issued regardless of enable; only the follow-on state changes.
                if (!enable)     state_d = ST_IDLE;
                else if (word_ok) state_d = ST_HOLD;
                else              state_d = ST_SYNC;
            end
            ST_HOLD: begin
                if (!enable)                   state_d = ST_IDLE;
                else if (hold_cnt_q == HD_LAST) state_d = ST_SYNC;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        rx_meta_d     = rx_in;
        rx_s_d        = rx_meta_q;
        rx_d_d        = rx_s_q;
        phase_d       = phase_q;
        chip_d        = chip_q;
        votes_d       = votes_q;
        shift_d       = shift_q;
        hold_cnt_d    = hold_cnt_q;
        m_seq_d       = m_seq_q;
        frame_count_d = frame_count_q;
        start_d       = 1'b0;
        reject_d      = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (rx_edge) begin
                    phase_d = PH_1;
                    chip_d  = '0;
                    votes_d = '0;
                end
            end
            ST_COLLECT: begin
                if (phase_last) begin
                    phase_d = '0;
                    votes_d = '0;
                    chip_d  = chip_q + CH_W'(1);
                    shift_d = {shift_q[CHIP_LEN-2:0], chip_bit};
                end else begin
                    phase_d = phase_q + PH_W'(1);
                    votes_d = vote_sum;
                end
            end
            ST_EMIT: begin
                if (word_ok) begin
                    m_seq_d       = shift_q;
                    start_d       = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    reject_d = 1'b1;
                end
                hold_cnt_d = '0;
            end
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HD_W'(1);
            end
            default: ;
        endcase

        // Dropping enable abandons any partial frame.
        if (!enable) begin
            phase_d = '0;
            chip_d  = '0;
            votes_d = '0;
            shift_d = '0;
        end

        // Set wins over clear when both happen together.
        overrun_d = overrun_q & enable;
        if (state_q == ST_HOLD && rx_edge) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            rx_meta_q     <= 1'b0;
            rx_s_q        <= 1'b0;
            rx_d_q        <= 1'b0;
            phase_q       <= '0;
            chip_q        <= '0;
            votes_q       <= '0;
            shift_q       <= '0;
            hold_cnt_q    <= '0;
            m_seq_q       <= '0;
            start_q       <= 1'b0;
            reject_q      <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            rx_d_q        <= rx_d_d;
            phase_q       <= phase_d;
            chip_q        <= chip_d;
            votes_q       <= votes_d;
            shift_q       <= shift_d;
            hold_cnt_q    <= hold_cnt_d;
            m_seq_q       <= m_seq_d;
            start_q       <= start_d;
            reject_q      <= reject_d;
            frame_count_q <= frame_count_d;
            overrun_q     <= overrun_d;
        end
    end

    assign m_sequence  = m_seq_q;
    assign start       = start_q;
    assign reject      = reject_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_chip_frame_deserializer.sv
// Purpose: directed, table-driven bench for chip_frame_deserializer (default parameters).
// Latency: expects start/reject exactly 30 cycles after rx_in first changes in SYNC.
// Backpressure: n/a; the bench drives rx_in one slot per cycle on the falling edge.
module tb_chip_frame_deserializer;

    logic       clk = 1'b0;
    logic       nRst;
    logic       enable;
    logic       rx_in;
    logic [6:0] m_sequence;
    logic       start;
    logic       reject;
    logic [7:0] frame_count;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    chip_frame_deserializer dut (
        .clk         (clk),
        .nRst        (nRst),
        .enable      (enable),
        .rx_in       (rx_in),
        .m_sequence  (m_sequence),
        .start       (start),
        .reject      (reject),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] chips;
        bit         glitch;
        bit         exp_start;
        bit         exp_reject;
        logic [6:0] exp_mseq;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Return the line to low while disabled so the next frame can open with a rising edge.
    task automatic park();
        @(negedge clk);
        enable = 1'b0;
        rx_in  = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Slot n is driven at the falling edge before rising edge n; outputs sampled there reflect edge n-1.
    task automatic send_frame(input logic [6:0] chips, input bit glitch, input bit toggle,
                              input bit exp_start, input bit exp_reject,
                              input logic [6:0] exp_mseq, input logic [7:0] exp_cnt,
                              input bit exp_ovr, input string name);
        int pulses;
        int bad;
        if (chips[6] == rx_in) park();
        pulses = 0;
        for (int n = 0; n < 31; n++) begin
            @(negedge clk);
            if (n < 28) begin
                rx_in = chips[6 - n / 4];
                if (glitch && n == 2) rx_in = ~chips[6];
            end
            if (start || reject) pulses++;
        end
        check({name, " early_pulse"}, pulses, 0);
        @(negedge clk);
        check({name, " start"}, start, exp_start);
        check({name, " reject"}, reject, exp_reject);
        check({name, " m_sequence"}, m_sequence, exp_mseq);
        check({name, " frame_count"}, frame_count, exp_cnt);
        bad = 0;
        for (int n = 32; n < 47; n++) begin
            @(negedge clk);
            if (toggle && (n == 33 || n == 35)) rx_in = ~rx_in;
            if (start || reject || m_sequence !== exp_mseq) bad++;
        end
        check({name, " hold_stable"}, bad, 0);
        check({name, " overrun"}, overrun, exp_ovr);
    endtask

    initial begin
        int pulses;
        logic [7:0] exp_cnt;
        logic [6:0] pat;

        vecs[0] = '{7'b1011100, 1'b0, 1'b1, 1'b0, 7'b1011100, 8'd1};
        vecs[1] = '{7'b1011100, 1'b1, 1'b1, 1'b0, 7'b1011100, 8'd2};
        vecs[2] = '{7'b1111111, 1'b0, 1'b0, 1'b1, 7'b1011100, 8'd2};
        vecs[3] = '{7'b1100101, 1'b0, 1'b1, 1'b0, 7'b1100101, 8'd3};
        vecs[4] = '{7'b0110010, 1'b0, 1'b1, 1'b0, 7'b0110010, 8'd4};
        vecs[5] = '{7'b1000001, 1'b0, 1'b1, 1'b0, 7'b1000001, 8'd5};
        vecs[6] = '{7'b0000000, 1'b0, 1'b0, 1'b1, 7'b1000001, 8'd5};
        vecs[7] = '{7'b1010101, 1'b0, 1'b1, 1'b0, 7'b1010101, 8'd6};

        // Reset state
        nRst   = 1'b0;
        enable = 1'b0;
        rx_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst start", start, 0);
        check("rst reject", reject, 0);
        check("rst m_sequence", m_sequence, 0);
        check("rst frame_count", frame_count, 0);
        check("rst overrun", overrun, 0);
        nRst   = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // Frame table: nominal, glitch, all-1 reject, falling-edge starts, all-0 reject
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].chips, vecs[i].glitch, 1'b0, vecs[i].exp_start, vecs[i].exp_reject,
                       vecs[i].exp_mseq, vecs[i].exp_count, 1'b0, $sformatf("vec%0d", i));
        end

        // Overrun: line activity during hold sets a sticky flag that survives later frames
        send_frame(7'b1011100, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1011100, 8'd7, 1'b1, "ovr_set");
        send_frame(7'b1110010, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1110010, 8'd8, 1'b1, "ovr_sticky");
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("ovr_clear", overrun, 0);
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // Abort after three chips
        pat = 7'b1100101;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            rx_in = pat[6 - n / 4];
            if (start || reject) pulses++;
        end
        @(negedge clk);
        enable = 1'b0;
        rx_in  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (start || reject) pulses++;
        end
        check("abort pulses", pulses, 0);
        check("abort m_sequence", m_sequence, 7'b1110010);
        check("abort frame_count", frame_count, 8'd8);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(7'b1100101, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1100101, 8'd9, 1'b0, "after_abort");

        // Reset mid-frame
        park();
        pat = 7'b1011100;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            rx_in = pat[6 - n / 4];
        end
        @(negedge clk);
        nRst  = 1'b0;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst start", start, 0);
        check("midrst reject", reject, 0);
        check("midrst m_sequence", m_sequence, 0);
        check("midrst frame_count", frame_count, 0);
        check("midrst overrun", overrun, 0);
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(7'b1011100, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1011100, 8'd1, 1'b0, "after_rst");

        // Counter wrap: 255 more accepted frames take the count from 1 through 255 to 0
        exp_cnt = 8'd1;
        for (int i = 0; i < 255; i++) begin
            pat = i[0] ? 7'b1011100 : 7'b1110010;
            exp_cnt = exp_cnt + 8'd1;
            send_frame(pat, 1'b0, 1'b0, 1'b1, 1'b0, pat, exp_cnt, 1'b0, $sformatf("wrap%0d", i));
        end
        check("wrap_zero", frame_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
